// File: rtl/serializer_pkg.sv
// Shared constants and state encoding for the encrypter-result serializer.
// All widths derive from the encrypter width and the encrypter count.
package serializer_pkg;

    localparam int ENCRYPTER_WIDTH          = 32;
    localparam int NUM_ENCRYPTERS           = 4;
    localparam int NUM_ENCRYPTERS_REG       = $clog2(NUM_ENCRYPTERS);
    localparam int ENCRYPTER_QSPI_COUNT     = ENCRYPTER_WIDTH / 4;
    localparam int ENCRYPTER_QSPI_COUNT_REG = $clog2(ENCRYPTER_QSPI_COUNT);

    // Terminal counter values, pre-sized so comparisons need no widening.
    localparam logic [NUM_ENCRYPTERS_REG-1:0] LAST_ENCRYPTER =
        NUM_ENCRYPTERS_REG'(NUM_ENCRYPTERS - 1);
    localparam logic [ENCRYPTER_QSPI_COUNT_REG-1:0] LAST_NIBBLE =
        ENCRYPTER_QSPI_COUNT_REG'(ENCRYPTER_QSPI_COUNT - 1);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/serializer_nibble_shifter.sv
// Packet holding register and nibble selector: streams a captured result
// least-significant nibble first, one nibble per accepted transfer.
module nibble_shifter
    import serializer_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       load,
    input  logic [ENCRYPTER_WIDTH-1:0] load_data,
    input  logic                       advance,
    input  logic                       show,
    output logic [3:0]                 qspi_data,
    output logic                       last_nibble
);

    logic [ENCRYPTER_WIDTH-1:0]          packet_reg;
    logic [ENCRYPTER_QSPI_COUNT_REG-1:0] nibble_index_reg;
    logic [3:0]                          nibbles [ENCRYPTER_QSPI_COUNT];

    genvar gi;
    generate
        for (gi = 0; gi < ENCRYPTER_QSPI_COUNT; gi++) begin : g_nibble
            assign nibbles[gi] = packet_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            packet_reg       <= '0;
            nibble_index_reg <= '0;
        end else if (clear) begin
            nibble_index_reg <= '0;
        end else if (load) begin
            packet_reg       <= load_data;
            nibble_index_reg <= '0;
        end else if (advance) begin
            nibble_index_reg <= last_nibble ? '0
                              : nibble_index_reg + ENCRYPTER_QSPI_COUNT_REG'(1);
        end
    end

    assign last_nibble = (nibble_index_reg == LAST_NIBBLE);
    // Idle output is forced to zero so the bus never shows a stale nibble.
    assign qspi_data   = show ? nibbles[nibble_index_reg] : 4'h0;

endmodule

// File: rtl/serializer.sv
// Round-robin collector of encrypter results, streamed out as QSPI nibbles
// in dispatch order; each captured result is acknowledged for one cycle.
module serializer
    import serializer_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      clear,
    input  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] encrypters_result,
    input  logic [NUM_ENCRYPTERS-1:0]                 encrypters_result_valid,
    output logic [NUM_ENCRYPTERS-1:0]                 encrypters_result_ack,
    output logic [3:0]                                qspi_data,
    output logic                                      qspi_sending,
    input  logic                                      qspi_ready,
    output logic                                      busy
);

    state_t                        state_reg, state_next;
    logic [NUM_ENCRYPTERS_REG-1:0] encrypter_index_reg, encrypter_index_next;
    logic [NUM_ENCRYPTERS-1:0]     ack_reg, ack_next;
    logic [ENCRYPTER_WIDTH-1:0]    slots [NUM_ENCRYPTERS];
    logic                          capture;
    logic                          advance;
    logic                          last_nibble;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENCRYPTERS; gi++) begin : g_slot
            assign slots[gi]    = encrypters_result[gi*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
            assign ack_next[gi] = capture && (encrypter_index_reg == NUM_ENCRYPTERS_REG'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg           <= ST_WAIT;
            encrypter_index_reg <= '0;
            ack_reg             <= '0;
        end else begin
            state_reg           <= state_next;
            encrypter_index_reg <= encrypter_index_next;
            ack_reg             <= ack_next;
        end
    end

    // clear outranks both capture and nibble advance.
    always_comb begin
        state_next           = state_reg;
        encrypter_index_next = encrypter_index_reg;
        capture              = 1'b0;
        advance              = 1'b0;
        if (clear) begin
            state_next           = ST_WAIT;
            encrypter_index_next = '0;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    if (encrypters_result_valid[encrypter_index_reg]) begin
                        capture    = 1'b1;
                        state_next = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (qspi_ready) begin
                        advance = 1'b1;
                        if (last_nibble) begin
                            state_next           = ST_WAIT;
                            encrypter_index_next = (encrypter_index_reg == LAST_ENCRYPTER) ? '0
                                : encrypter_index_reg + NUM_ENCRYPTERS_REG'(1);
                        end
                    end
                end
                default: state_next = ST_WAIT;
            endcase
        end
    end

    assign qspi_sending          = (state_reg == ST_SEND);
    assign busy                  = (state_reg != ST_WAIT);
    assign encrypters_result_ack = ack_reg;

    nibble_shifter u_nibble_shifter (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .load        (capture),
        .load_data   (slots[encrypter_index_reg]),
        .advance     (advance),
        .show        (qspi_sending),
        .qspi_data   (qspi_data),
        .last_nibble (last_nibble)
    );

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: stimulus pushes expected acks and nibbles,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_serializer;
    import serializer_pkg::*;

    localparam int W = ENCRYPTER_WIDTH;
    localparam int N = NUM_ENCRYPTERS;
    localparam int Q = ENCRYPTER_QSPI_COUNT;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           clear = 1'b0;
    logic           qspi_ready = 1'b1;
    logic [N*W-1:0] encrypters_result = '0;
    logic [N-1:0]   encrypters_result_valid = '0;
    logic [N-1:0]   encrypters_result_ack;
    logic [3:0]     qspi_data;
    logic           qspi_sending;
    logic           busy;

    typedef struct {
        string       name;
        logic [31:0] got;
        logic [31:0] exp;
    } check_t;

    logic [3:0]   exp_nib[$];
    logic [N-1:0] exp_ack[$];
    check_t       check_q[$];
    int           checks = 0;
    int           errors = 0;

    serializer dut (
        .clk                     (clk),
        .reset                   (reset),
        .clear                   (clear),
        .encrypters_result       (encrypters_result),
        .encrypters_result_valid (encrypters_result_valid),
        .encrypters_result_ack   (encrypters_result_ack),
        .qspi_data               (qspi_data),
        .qspi_sending            (qspi_sending),
        .qspi_ready              (qspi_ready),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    // Monitor: the only process that counts comparisons.
    initial begin
        check_t       mc;
        logic [3:0]   mn;
        logic [N-1:0] ma;
        forever begin
            @(negedge clk);
            while (check_q.size() > 0) begin
                mc = check_q.pop_front();
                checks++;
                if (mc.got !== mc.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", mc.name, mc.got, mc.exp);
                end
            end
            if (reset) begin
                if (encrypters_result_ack !== '0) begin
                    checks++;
                    if (exp_ack.size() == 0) begin
                        errors++;
                        $display("FAIL ack_unexpected: got %b expected none", encrypters_result_ack);
                    end else begin
                        ma = exp_ack.pop_front();
                        if (encrypters_result_ack !== ma) begin
                            errors++;
                            $display("FAIL ack_order: got %b expected %b", encrypters_result_ack, ma);
                        end else
                            $display("ack   %b", encrypters_result_ack);
                    end
                end
                if (qspi_sending && qspi_ready && !clear) begin
                    checks++;
                    if (exp_nib.size() == 0) begin
                        errors++;
                        $display("FAIL nibble_unexpected: got %h expected none", qspi_data);
                    end else begin
                        mn = exp_nib.pop_front();
                        if (qspi_data !== mn) begin
                            errors++;
                            $display("FAIL nibble_data: got %h expected %h", qspi_data, mn);
                        end else
                            $display("nibble %h", qspi_data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_chk(string name, logic [31:0] got, logic [31:0] exp);
        check_t c;
        c.name = name;
        c.got  = got;
        c.exp  = exp;
        check_q.push_back(c);
    endfunction

    function automatic void expect_packet(int k, logic [W-1:0] d, int nibbles);
        logic [N-1:0] one_hot;
        one_hot = N'(1) << k;
        exp_ack.push_back(one_hot);
        for (int i = 0; i < nibbles; i++) exp_nib.push_back(d[4*i +: 4]);
    endfunction

    function automatic void set_slot(int k, logic [W-1:0] d);
        encrypters_result[k*W +: W] = d;
    endfunction

    // Drops each valid bit on its ack; returns once nothing is pending.
    task automatic run_until_idle(output int sending_cycles, output int total_cycles);
        bit done;
        done = 1'b0;
        sending_cycles = 0;
        total_cycles = 0;
        while (!done && total_cycles < 400) begin
            tick();
            total_cycles++;
            if (qspi_sending) sending_cycles++;
            encrypters_result_valid = encrypters_result_valid & ~encrypters_result_ack;
            if (encrypters_result_valid == '0 && !busy) done = 1'b1;
        end
        expect_chk("idle_timeout", 32'(done), 1);
    endtask

    initial begin
        int cyc;
        int tot;

        repeat (3) @(posedge clk);
        #1;
        expect_chk("reset_sending", 32'(qspi_sending), 0);
        expect_chk("reset_data", 32'(qspi_data), 0);
        expect_chk("reset_ack", 32'(encrypters_result_ack), 0);
        expect_chk("reset_busy", 32'(busy), 0);
        reset = 1'b1;
        tick();

        // Basic packet from encrypter 0.
        set_slot(0, 32'h87654321);
        expect_packet(0, 32'h87654321, Q);
        encrypters_result_valid[0] = 1'b1;
        tick();
        expect_chk("basic_latency_ack", 32'(encrypters_result_ack), 1);
        expect_chk("basic_latency_sending", 32'(qspi_sending), 1);
        encrypters_result_valid[0] = 1'b0;
        run_until_idle(cyc, tot);
        expect_chk("basic_sending_cycles", cyc + 1, Q);
        expect_chk("basic_framed", 32'(qspi_sending), 0);

        // Order enforcement: later encrypters wait for encrypter 0.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_slot(0, 32'hA0A1A2A3);
        set_slot(1, 32'hB4B5B6B7);
        set_slot(2, 32'hC8C9CACB);
        set_slot(3, 32'hDCDDDEDF);
        encrypters_result_valid[2] = 1'b1;
        encrypters_result_valid[1] = 1'b1;
        repeat (4) tick();
        expect_chk("order_no_ack", 32'(encrypters_result_ack), 0);
        expect_chk("order_not_busy", 32'(busy), 0);
        expect_packet(0, 32'hA0A1A2A3, Q);
        expect_packet(1, 32'hB4B5B6B7, Q);
        expect_packet(2, 32'hC8C9CACB, Q);
        encrypters_result_valid[0] = 1'b1;
        run_until_idle(cyc, tot);
        expect_chk("order_sending_cycles", cyc, 3 * Q);
        expect_chk("order_spacing_cycles", tot, 3 * (Q + 1));
        set_slot(0, 32'h0F1E2D3C);
        expect_packet(3, 32'hDCDDDEDF, Q);
        expect_packet(0, 32'h0F1E2D3C, Q);
        encrypters_result_valid[3] = 1'b1;
        encrypters_result_valid[0] = 1'b1;
        run_until_idle(cyc, tot);
        expect_chk("wrap_sending_cycles", cyc, 2 * Q);

        // Backpressure on nibble 2 of encrypter 1.
        set_slot(1, 32'h87654321);
        expect_packet(1, 32'h87654321, Q);
        encrypters_result_valid[1] = 1'b1;
        tick();
        encrypters_result_valid[1] = 1'b0;
        tick();
        tick();
        expect_chk("bp_shown", 32'(qspi_data), 3);
        qspi_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_chk("bp_hold_data", 32'(qspi_data), 3);
            expect_chk("bp_hold_sending", 32'(qspi_sending), 1);
        end
        qspi_ready = 1'b1;
        run_until_idle(cyc, tot);
        expect_chk("bp_all_nibbles", exp_nib.size(), 0);

        // Clear after 4 nibbles of encrypter 1.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_slot(0, 32'h11223344);
        expect_packet(0, 32'h11223344, Q);
        encrypters_result_valid[0] = 1'b1;
        run_until_idle(cyc, tot);
        set_slot(1, 32'hFEDCBA98);
        expect_packet(1, 32'hFEDCBA98, 4);
        encrypters_result_valid[1] = 1'b1;
        tick();
        encrypters_result_valid[1] = 1'b0;
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_chk("clear_sending", 32'(qspi_sending), 0);
        expect_chk("clear_busy", 32'(busy), 0);
        expect_chk("clear_ack", 32'(encrypters_result_ack), 0);
        set_slot(2, 32'h55555555);
        encrypters_result_valid[2] = 1'b1;
        repeat (4) tick();
        expect_chk("clear_not_from_2", 32'(busy), 0);
        set_slot(0, 32'h6789ABCD);
        expect_packet(0, 32'h6789ABCD, Q);
        encrypters_result_valid[2] = 1'b0;
        encrypters_result_valid[0] = 1'b1;
        run_until_idle(cyc, tot);

        // Asynchronous reset during the first cycle of a packet.
        set_slot(1, 32'h13579BDF);
        encrypters_result_valid[1] = 1'b1;
        tick();
        encrypters_result_valid[1] = 1'b0;
        expect_chk("rst_pre_ack", 32'(encrypters_result_ack), 2);
        expect_chk("rst_pre_data", 32'(qspi_data), 32'hF);
        #2;
        reset = 1'b0;
        #1;
        expect_chk("rst_async_sending", 32'(qspi_sending), 0);
        expect_chk("rst_async_data", 32'(qspi_data), 0);
        expect_chk("rst_async_ack", 32'(encrypters_result_ack), 0);
        expect_chk("rst_async_busy", 32'(busy), 0);
        tick();
        tick();
        reset = 1'b1;
        encrypters_result_valid[1] = 1'b1;
        repeat (4) tick();
        expect_chk("rst_resume_not_1", 32'(busy), 0);
        set_slot(0, 32'h2468ACE0);
        expect_packet(0, 32'h2468ACE0, Q);
        encrypters_result_valid[1] = 1'b0;
        encrypters_result_valid[0] = 1'b1;
        run_until_idle(cyc, tot);

        // Clear and valid on the same edge.
        clear = 1'b1;
        tick();
        set_slot(0, 32'h9ABCDEF0);
        encrypters_result_valid[0] = 1'b1;
        tick();
        expect_chk("collide_no_ack", 32'(encrypters_result_ack), 0);
        expect_chk("collide_not_busy", 32'(busy), 0);
        clear = 1'b0;
        expect_packet(0, 32'h9ABCDEF0, Q);
        tick();
        expect_chk("collide_capture_next", 32'(encrypters_result_ack), 1);
        encrypters_result_valid[0] = 1'b0;
        run_until_idle(cyc, tot);

        expect_chk("final_nibbles_left", exp_nib.size(), 0);
        expect_chk("final_acks_left", exp_ack.size(), 0);
        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low; ports are named clk and reset as elsewhere in the codebase.
REQ-002 Port list SHALL be, in this order:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- clear  in  1  synchronous stream restart
- encrypters_result  in  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened results; slot k = bits [k*W+W-1:k*W]
- encrypters_result_valid  in  NUM_ENCRYPTERS  per-encrypter result-valid
- encrypters_result_ack  out  NUM_ENCRYPTERS  per-encrypter one-cycle acknowledge
- qspi_data  out  4  outgoing nibble
- qspi_sending  out  1  nibble on qspi_data is valid
- qspi_ready  in  1  host accepts the nibble this cycle
- busy  out  1  high in any state other than WAIT

Function
REQ-003 The FSM SHALL have exactly two states: WAIT (waiting for the current encrypter's result) and SEND (streaming nibbles).
REQ-004 Results SHALL be collected strictly round-robin, starting at encrypter_index 0 and going 0,1,...,NUM_ENCRYPTERS-1,0, so that output order matches dispatch order.
REQ-005 In WAIT, only encrypters_result_valid[encrypter_index] SHALL be considered; valid bits of all other encrypters are ignored.
REQ-006 On a rising edge in WAIT with valid[encrypter_index]=1, the block SHALL:
- capture slot encrypter_index into the packet register
- set nibble_index to 0
- enter SEND.
REQ-007 encrypters_result_ack[encrypter_index] SHALL be high for exactly the one cycle following capture; every other ack bit stays 0.
REQ-008 In SEND, qspi_sending SHALL be 1 and qspi_data SHALL equal packet bits [4*nibble_index+3:4*nibble_index] (least-significant nibble first).
REQ-009 nibble_index SHALL advance only on a rising edge where qspi_sending=1 and qspi_ready=1. With qspi_ready=0, qspi_data and nibble_index hold.
REQ-010 When nibble ENCRYPTER_QSPI_COUNT-1 is accepted, the block SHALL:
- return to WAIT
- increment encrypter_index modulo NUM_ENCRYPTERS (wrap from N-1 to 0)
- drive qspi_sending low for at least one cycle, which frames each packet.
REQ-011 Latency: qspi_sending SHALL rise in the cycle after the capture edge, so the first nibble appears 1 cycle after valid is sampled. One packet with qspi_ready held high occupies exactly ENCRYPTER_QSPI_COUNT cycles of qspi_sending.
REQ-012 Minimum spacing between packets SHALL be ENCRYPTER_QSPI_COUNT+1 cycles: 1 cycle in WAIT plus the nibbles.
REQ-013 clear=1 on any edge SHALL:
- abort an in-progress packet
- set encrypter_index=0 and nibble_index=0
- enter WAIT
- drive qspi_sending=0 and the ack outputs to 0 on the next cycle.
clear takes priority over capture and over nibble advance in the same cycle.
REQ-014 A result that is valid at the same edge as clear SHALL NOT be captured or acknowledged.
REQ-015 busy SHALL be 0 exactly when in WAIT.
REQ-016 The width of encrypter_index SHALL be NUM_ENCRYPTERS_REG, and the width of nibble_index SHALL be ENCRYPTER_QSPI_COUNT_REG. Both counters compare to their terminal values before wrapping, with no overflow.

Reset
REQ-017 While reset=0, the block SHALL asynchronously force:
- state=WAIT, encrypter_index=0, nibble_index=0, packet register=0
- qspi_data=4'h0, qspi_sending=0, encrypters_result_ack=0, busy=0.
REQ-018 Reset asserted mid-SEND SHALL drop the packet immediately, with no partial completion. After deassertion, operation SHALL resume at encrypter 0.

Structure
REQ-019 ENCRYPTER_WIDTH, NUM_ENCRYPTERS, NUM_ENCRYPTERS_REG, ENCRYPTER_QSPI_COUNT and ENCRYPTER_QSPI_COUNT_REG SHALL come from the shared constants file and SHALL NOT be redefined locally. The state encodings SHALL also be defined there.
REQ-020 The nibble shift/select datapath (packet register, nibble_index, qspi_data mux) SHALL be one sub-module named nibble_shifter. The FSM, round-robin index and ack logic remain in serializer.

Verification (bench: ENCRYPTER_WIDTH=32, NUM_ENCRYPTERS=4, ENCRYPTER_QSPI_COUNT=8)
REQ-021 Basic packet: valid[0]=1 with slot0=32'h87654321 and qspi_ready=1. Required: ack[0] pulses for 1 cycle, then qspi_data = 1,2,3,4,5,6,7,8 on 8 consecutive cycles with qspi_sending=1, then qspi_sending=0.
REQ-022 Order enforcement: valid[2] and valid[1] asserted before valid[0]. Required: no ack until valid[0]. Output order is slot0, slot1, slot2. Then slot3, then the index wraps and slot0 is accepted again.
REQ-023 Backpressure: qspi_ready=0 for 3 cycles after nibble 2 is shown. Required: qspi_data holds 4'h3 for those cycles, and the packet still ends with 8 accepted nibbles in order.
REQ-024 Clear mid-packet: clear=1 after 4 nibbles of slot1. Required: qspi_sending=0 the next cycle, busy=0, and the next capture comes from encrypter 0, not encrypter 2.
REQ-025 Reset mid-packet: reset=0 asynchronously during SEND. Required: qspi_sending, qspi_data and ack go to 0 without waiting for a clock edge, and the first packet after release comes from encrypter 0.
REQ-026 Clear/valid collision: clear=1 and valid[0]=1 on the same edge. Required: no ack[0]; the capture happens on the next edge where valid[0]=1 and clear=0.
